// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // Saturation limits are returned 64 bits wide; callers trim to their width.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// One slice of the split carry chain: CHUNK-bit adder with carry in and out.
module addsub_chunk #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/subtract with valid/ready and status flags.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             cb,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    logic stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Stage k adds chunk k; only the operand bits above it travel on, and the
    // finished low result bits ride along until they reach the output.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam int UP = WIDTH - LO;

        logic [UP-1:0]       a_in;
        logic [UP-1:0]       b_in;
        logic                c_in;
        logic                op_in;
        logic                v_in;
        logic [CHUNK-1:0]    sum;
        logic                cout;
        logic [LO+CHUNK-1:0] res;

        if (k == 0) begin : g_head
            assign a_in  = A;
            assign b_in  = (op == OP_SUB) ? ~B : B;
            assign c_in  = op;
            assign op_in = op;
            assign v_in  = in_valid;
            assign res   = sum;
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_reg.a_q;
            assign b_in  = g_stage[k-1].g_reg.b_q;
            assign c_in  = g_stage[k-1].g_reg.c_q;
            assign op_in = g_stage[k-1].g_reg.op_q;
            assign v_in  = g_stage[k-1].g_reg.v_q;
            assign res   = {sum, g_stage[k-1].g_reg.y_q};
        end

        addsub_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (a_in[CHUNK-1:0]),
            .b    (b_in[CHUNK-1:0]),
            .cin  (c_in),
            .sum  (sum),
            .cout (cout)
        );

        if (k < LAST) begin : g_reg
            logic [UP-CHUNK-1:0] a_q;
            logic [UP-CHUNK-1:0] b_q;
            logic [LO+CHUNK-1:0] y_q;
            logic                c_q;
            logic                op_q;
            logic                v_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    y_q  <= '0;
                    c_q  <= 1'b0;
                    op_q <= 1'b0;
                    v_q  <= 1'b0;
                end else if (!stall) begin
                    a_q  <= a_in[UP-1:CHUNK];
                    b_q  <= b_in[UP-1:CHUNK];
                    y_q  <= res;
                    c_q  <= cout;
                    op_q <= op_in;
                    v_q  <= v_in;
                end
            end
        end
    end

    logic [WIDTH-1:0] y_raw;
    logic [WIDTH-1:0] y_nxt;
    logic             a_msb;
    logic             b_msb;
    logic             ovf_nxt;
    logic             cb_nxt;

    assign y_raw   = g_stage[LAST].res;
    assign a_msb   = g_stage[LAST].a_in[CHUNK-1];
    assign b_msb   = g_stage[LAST].b_in[CHUNK-1];
    assign ovf_nxt = (a_msb == b_msb) && (y_raw[WIDTH-1] != a_msb);
    assign cb_nxt  = g_stage[LAST].op_in ? ~g_stage[LAST].cout : g_stage[LAST].cout;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    assign y_nxt = ovf_nxt ? (a_msb ? SAT_MIN : SAT_MAX) : y_raw;
`else
    assign y_nxt = y_raw;
`endif

    // Result and flags only change when a real result lands, so bubbles
    // leave the last delivered values in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Y         <= '0;
            cb        <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (!stall) begin
            out_valid <= g_stage[LAST].v_in;
            if (g_stage[LAST].v_in) begin
                Y    <= y_nxt;
                cb   <= cb_nxt;
                ovf  <= ovf_nxt;
                zero <= (y_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: three configurations sharing one stimulus
// sequence, checked against a signed-arithmetic reference model.
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int W0 = 32;
    localparam int S0 = 2;
    localparam int W1 = 64;
    localparam int S1 = 1;
    localparam int W2 = 64;
    localparam int S2 = 8;

    typedef struct packed {
        logic [63:0] y;
        logic        cb;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        op;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  sel;

    logic        iv0, iv1, iv2;
    logic        ir0, ir1, ir2;
    logic        ov0, ov1, ov2;
    logic [31:0] y0;
    logic [63:0] y1, y2;
    logic        cb0, cb1, cb2;
    logic        of0, of1, of2;
    logic        z0, z1, z2;

    logic        cur_ir, cur_ov, cur_cb, cur_ovf, cur_zero;
    logic [63:0] cur_y;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   popped = 0;
    res_t q[$];
    bit   prev_stall = 0;
    res_t hold;

    always #5 clk = ~clk;

    assign iv0 = in_valid && (sel == 2'd0);
    assign iv1 = in_valid && (sel == 2'd1);
    assign iv2 = in_valid && (sel == 2'd2);

    addsub_pipe #(.WIDTH(W0), .STAGES(S0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .op(op),
        .A(a[31:0]), .B(b[31:0]), .out_valid(ov0), .out_ready(out_ready),
        .Y(y0), .cb(cb0), .ovf(of0), .zero(z0)
    );

    addsub_pipe #(.WIDTH(W1), .STAGES(S1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op),
        .A(a), .B(b), .out_valid(ov1), .out_ready(out_ready),
        .Y(y1), .cb(cb1), .ovf(of1), .zero(z1)
    );

    addsub_pipe #(.WIDTH(W2), .STAGES(S2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .op(op),
        .A(a), .B(b), .out_valid(ov2), .out_ready(out_ready),
        .Y(y2), .cb(cb2), .ovf(of2), .zero(z2)
    );

    always_comb begin
        cur_ir   = ir0;
        cur_ov   = ov0;
        cur_y    = {32'd0, y0};
        cur_cb   = cb0;
        cur_ovf  = of0;
        cur_zero = z0;
        case (sel)
            2'd1: begin
                cur_ir = ir1; cur_ov = ov1; cur_y = y1;
                cur_cb = cb1; cur_ovf = of1; cur_zero = z1;
            end
            2'd2: begin
                cur_ir = ir2; cur_ov = ov2; cur_y = y2;
                cur_cb = cb2; cur_ovf = of2; cur_zero = z2;
            end
            default: ;
        endcase
    end

    function automatic int width_of(input logic [1:0] s);
        return (s == 2'd0) ? W0 : ((s == 2'd1) ? W1 : W2);
    endfunction

    function automatic int stages_of(input logic [1:0] s);
        return (s == 2'd0) ? S0 : ((s == 2'd1) ? S1 : S2);
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference: exact signed result, then wrap (or clamp) to the operand width.
    function automatic res_t model(input int w, input logic sub, input logic [63:0] x, input logic [63:0] yv);
        logic signed [67:0] sx, sy, t, lim;
        logic [67:0]        ux, uy;
        res_t               r;
        ux = {4'b0, x};
        uy = {4'b0, yv};
        sx = $signed(ux);
        sy = $signed(uy);
        if (x[w-1])  sx = sx - (68'sd1 <<< w);
        if (yv[w-1]) sy = sy - (68'sd1 <<< w);
        t   = sub ? (sx - sy) : (sx + sy);
        lim = 68'sd1 <<< (w - 1);
        r.ovf = (t >= lim) || (t < -lim);
        r.cb  = sub ? (ux < uy) : (((ux + uy) >> w) != 68'd0);
        r.y   = t[63:0] & wmask(w);
`ifdef ADDSUB_SAT_EN
        if (r.ovf) r.y = (t > 0) ? (wmask(w) >> 1) : (~(wmask(w) >> 1) & wmask(w));
`endif
        r.zero = (r.y == 64'd0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        res_t e;
        if (q.size() == 0) begin
            chk("stale_out_valid", 64'(cur_ov), 64'd0);
        end else begin
            e = q.pop_front();
            popped++;
            chk("Y", cur_y, e.y);
            chk("cb", 64'(cur_cb), 64'(e.cb));
            chk("ovf", 64'(cur_ovf), 64'(e.ovf));
            chk("zero", 64'(cur_zero), 64'(e.zero));
        end
    endtask

    // One clock: sample handshakes just after the inputs settle, then advance
    // to the next falling edge where the caller drives new inputs.
    task automatic cycle(output bit acc);
        #1;
        acc = 0;
        if (rst) begin
            q.delete();
            prev_stall = 0;
        end else begin
            chk("in_ready", 64'(cur_ir), 64'(!(cur_ov && !out_ready)));
            if (cur_ov && !out_ready) begin
                if (prev_stall) begin
                    chk("stall_Y", cur_y, hold.y);
                    chk("stall_flags", 64'({cur_cb, cur_ovf, cur_zero}), 64'({hold.cb, hold.ovf, hold.zero}));
                end
                hold.y    = cur_y;
                hold.cb   = cur_cb;
                hold.ovf  = cur_ovf;
                hold.zero = cur_zero;
                prev_stall = 1;
            end else begin
                prev_stall = 0;
            end
            if (cur_ov && out_ready) checkOutput();
            if (in_valid && cur_ir) begin
                q.push_back(model(width_of(sel), op, a, b));
                acc = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic applyStimulus(input logic v, input logic o, input logic [63:0] x,
                                 input logic [63:0] yv, input logic rdy, output bit acc);
        in_valid  = v;
        op        = o;
        a         = x;
        b         = yv;
        out_ready = rdy;
        cycle(acc);
    endtask

    task automatic drain(input int maxc);
        bit acc;
        int n;
        n = 0;
        while (q.size() != 0 && n < maxc) begin
            applyStimulus(0, 0, 64'd0, 64'd0, 1, acc);
            n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        applyStimulus(0, 0, 64'd0, 64'd0, 1, acc);
        chk("idle_out_valid", 64'(cur_ov), 64'd0);
    endtask

    task automatic directed(input string tag, input logic o, input logic [63:0] x, input logic [63:0] yv,
                            input logic [63:0] ey, input logic ecb, input logic eovf, input logic ez);
        bit acc;
        int lat;
        applyStimulus(1, o, x, yv, 1, acc);
        chk({tag, "_accept"}, 64'(acc), 64'd1);
        lat = 1;
        while (!cur_ov && lat < 20) begin
            applyStimulus(0, 0, 64'd0, 64'd0, 1, acc);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(stages_of(sel)));
        chk({tag, "_Y"}, cur_y, ey);
        chk({tag, "_cb"}, 64'(cur_cb), 64'(ecb));
        chk({tag, "_ovf"}, 64'(cur_ovf), 64'(eovf));
        chk({tag, "_zero"}, 64'(cur_zero), 64'(ez));
        applyStimulus(0, 0, 64'd0, 64'd0, 1, acc);
    endtask

    function automatic logic [63:0] rnd(input int w);
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = wmask(w) >> 1;
            1: v = ~(wmask(w) >> 1);
            2: v = 64'd0;
            default: ;
        endcase
        return v & wmask(w);
    endfunction

    task automatic randomRun(input int n);
        bit acc;
        for (int i = 0; i < n; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          rnd(width_of(sel)), rnd(width_of(sel)), $urandom_range(0, 3) != 0, acc);
        end
    endtask

    task automatic resetMidStream();
        bit acc;
        applyStimulus(1, 0, rnd(width_of(sel)), rnd(width_of(sel)), 1, acc);
        applyStimulus(1, 1, rnd(width_of(sel)), rnd(width_of(sel)), 1, acc);
        rst = 1;
        applyStimulus(1, 0, rnd(width_of(sel)), rnd(width_of(sel)), 0, acc);
        rst = 0;
        chk("rst_out_valid", 64'(cur_ov), 64'd0);
        chk("rst_Y", cur_y, 64'd0);
        chk("rst_flags", 64'({cur_cb, cur_ovf, cur_zero}), 64'd0);
        chk("rst_in_ready", 64'(cur_ir), 64'd1);
        for (int i = 0; i < stages_of(sel) + 2; i++) begin
            applyStimulus(0, 0, 64'd0, 64'd0, 1, acc);
            chk("post_rst_idle", 64'(cur_ov), 64'd0);
        end
    endtask

    initial begin
        if ((W0 % S0 != 0) || (W1 % S1 != 0) || (W2 % S2 != 0)) begin
            $display("[TB] FAIL elab WIDTH not divisible by STAGES");
            $fatal(1, "[TB] bad configuration");
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bit acc;
        int start, sent, guard, p0;
        logic        bo;
        logic [63:0] bx, by;

        sel = 2'd0; rst = 1; in_valid = 0; op = 0; a = '0; b = '0; out_ready = 1;
        cycle(acc);
        cycle(acc);
        rst = 0;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_out_valid", 64'(cur_ov), 64'd0);
            chk("reset_in_ready", 64'(cur_ir), 64'd1);
            chk("reset_Y", cur_y, 64'd0);
            chk("reset_flags", 64'({cur_cb, cur_ovf, cur_zero}), 64'd0);
        end
        sel = 2'd0;
        @(negedge clk);

        $display("[TB] directed WIDTH=32 STAGES=2");
        directed("sub_small", 1, 64'd5, 64'd7, 64'hFFFF_FFFE, 1, 0, 0);
`ifdef ADDSUB_SAT_EN
        directed("add_ovf", 0, 64'h7FFF_FFFF, 64'd1, 64'h7FFF_FFFF, 0, 1, 0);
        directed("sub_ovf", 1, 64'h8000_0000, 64'd1, 64'h8000_0000, 0, 1, 0);
`else
        directed("add_ovf", 0, 64'h7FFF_FFFF, 64'd1, 64'h8000_0000, 0, 1, 0);
        directed("sub_ovf", 1, 64'h8000_0000, 64'd1, 64'h7FFF_FFFF, 0, 1, 0);
`endif
        directed("eq_sub", 1, 64'h1234_5678, 64'h1234_5678, 64'd0, 0, 0, 1);
        directed("add_ff", 0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 1, 0, 0);

        // Six back-to-back operations with the consumer stalling in cycles 3..5.
        $display("[TB] backpressure");
        p0 = popped; start = cyc; sent = 0; guard = 0;
        bo = 1'($urandom_range(0, 1)); bx = rnd(W0); by = rnd(W0);
        while (sent < 6 && guard < 40) begin
            applyStimulus(1, bo, bx, by, !((cyc - start) >= 3 && (cyc - start) <= 5), acc);
            if (acc) begin
                sent++;
                bo = 1'($urandom_range(0, 1)); bx = rnd(W0); by = rnd(W0);
            end
            guard++;
        end
        chk("bp_sent", 64'(sent), 64'd6);
        drain(40);
        chk("bp_results", 64'(popped - p0), 64'd6);

        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            $display("[TB] random and reset, config %0d", s);
            randomRun(60);
            drain(60);
            resetMidStream();
            randomRun(30);
            drain(60);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
